// File: rtl/spi_lcd_rx_decoder_if.sv
// Byte-stream output of the LCD SPI receiver: received byte, tags and valid/ready handshake.
// master = decoder side, slave = consumer side.
interface spi_lcd_rx_decoder_if #(
    parameter int unsigned CNT_W = 16
) ();
    logic [7:0]       BYTE_OUT;
    logic             BYTE_DC;
    logic [7:0]       PARAM_IDX;
    logic [7:0]       LAST_CMD;
    logic             BYTE_VALID;
    logic             BYTE_READY;
    logic             FRAME_ERR;
    logic             OVERRUN;
    logic [CNT_W-1:0] BYTE_COUNT;

    modport master (
        output BYTE_OUT, BYTE_DC, PARAM_IDX, LAST_CMD, BYTE_VALID, FRAME_ERR, OVERRUN,
               BYTE_COUNT,
        input  BYTE_READY
    );

    modport slave (
        input  BYTE_OUT, BYTE_DC, PARAM_IDX, LAST_CMD, BYTE_VALID, FRAME_ERR, OVERRUN,
               BYTE_COUNT,
        output BYTE_READY
    );
endinterface

// File: rtl/spi_lcd_rx_decoder.sv
// Passive 4-wire LCD SPI receiver: oversamples CS/SCL/DC/MOSI on CLK, deserialises bytes
// MSB-first and tags them as command or parameter on a valid/ready output register.
module spi_lcd_rx_decoder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  SCL,
    input  logic                  CS,
    input  logic                  DC,
    input  logic                  MOSI,
    spi_lcd_rx_decoder_if.master  bus
);

    typedef enum logic [1:0] {StIdle, StShift, StAbort} state_e;

    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_dc_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_scl_prev;

    state_e                 r_state;
    logic [6:0]             r_shift;
    logic [2:0]             r_bit_cnt;
    logic [7:0]             r_param_cnt;

    logic [7:0]             r_byte_out;
    logic                   r_byte_dc;
    logic [7:0]             r_param_idx;
    logic [7:0]             r_last_cmd;
    logic                   r_valid;
    logic                   r_frame_err;
    logic                   r_overrun;
    logic [CNT_W-1:0]       r_byte_count;

    logic                   w_cs;
    logic                   w_scl;
    logic                   w_dc;
    logic                   w_mosi;
    logic                   w_scl_rise;
    logic [7:0]             w_byte;
    logic [7:0]             w_param_nxt;
    logic                   w_free;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_cs_sync   <= {SYNC_STAGES{1'b1}};
            r_scl_sync  <= '0;
            r_dc_sync   <= '0;
            r_mosi_sync <= '0;
            r_scl_prev  <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], CS};
            r_scl_sync  <= {r_scl_sync[SYNC_STAGES-2:0], SCL};
            r_dc_sync   <= {r_dc_sync[SYNC_STAGES-2:0], DC};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
            r_scl_prev  <= r_scl_sync[SYNC_STAGES-1];
        end
    end

    assign w_cs        = r_cs_sync[SYNC_STAGES-1];
    assign w_scl       = r_scl_sync[SYNC_STAGES-1];
    assign w_dc        = r_dc_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_scl_rise  = w_scl & ~r_scl_prev;
    assign w_byte      = {r_shift, w_mosi};
    assign w_free      = !r_valid || bus.BYTE_READY;
    assign w_param_nxt = !w_dc ? 8'd0 :
                         (r_param_cnt == 8'hFF) ? 8'hFF : r_param_cnt + 8'd1;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state      <= StIdle;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_param_cnt  <= '0;
            r_byte_out   <= '0;
            r_byte_dc    <= 1'b0;
            r_param_idx  <= '0;
            r_last_cmd   <= '0;
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
            r_byte_count <= '0;
        end else begin
            r_frame_err <= 1'b0;
            // A load later in this block overrides this clear.
            if (r_valid && bus.BYTE_READY) begin
                r_valid <= 1'b0;
            end
            case (r_state)
                StIdle: begin
                    r_bit_cnt <= '0;
                    if (!w_cs) begin
                        r_state <= StShift;
                    end
                end
                StShift: begin
                    // CS deassertion takes priority over a coincident SCL edge.
                    if (w_cs) begin
                        if (r_bit_cnt == 3'd0) begin
                            r_state <= StIdle;
                        end else begin
                            r_state     <= StAbort;
                            r_frame_err <= 1'b1;
                        end
                    end else if (w_scl_rise) begin
                        r_shift   <= w_byte[6:0];
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_param_cnt <= w_param_nxt;
                            if (!w_dc) begin
                                r_last_cmd <= w_byte;
                            end
                            if (w_free) begin
                                r_byte_out   <= w_byte;
                                r_byte_dc    <= w_dc;
                                r_param_idx  <= w_param_nxt;
                                r_valid      <= 1'b1;
                                r_byte_count <= r_byte_count + 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                        end
                    end
                end
                StAbort: begin
                    r_bit_cnt <= '0;
                    r_shift   <= '0;
                    r_state   <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.BYTE_OUT   = r_byte_out;
    assign bus.BYTE_DC    = r_byte_dc;
    assign bus.PARAM_IDX  = r_param_idx;
    assign bus.LAST_CMD   = r_last_cmd;
    assign bus.BYTE_VALID = r_valid;
    assign bus.FRAME_ERR  = r_frame_err;
    assign bus.OVERRUN    = r_overrun;
    assign bus.BYTE_COUNT = r_byte_count;

endmodule

// File: tb/tb_spi_lcd_rx_decoder.sv
// Self-checking bench for spi_lcd_rx_decoder: drives the LCD SPI bus and compares the
// accepted byte stream against a byte-level reference model.
module tb_spi_lcd_rx_decoder;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    logic SCL = 1'b0;
    logic CS = 1'b1;
    logic DC = 1'b0;
    logic MOSI = 1'b0;

    spi_lcd_rx_decoder_if #(.CNT_W(16)) bus ();

    spi_lcd_rx_decoder #(
        .SYNC_STAGES(2),
        .CNT_W(16)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .SCL(SCL),
        .CS(CS),
        .DC(DC),
        .MOSI(MOSI),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          ferr_cnt = 0;
    logic [16:0] obs_q[$];
    logic [16:0] exp_q[$];

    // Reference model state: byte-level view of the bus.
    logic [7:0]  m_last_cmd = 8'd0;
    logic [7:0]  m_pidx = 8'd0;
    logic [15:0] m_count = 16'd0;

    always @(negedge CLK) begin
        if (RST_N && bus.BYTE_VALID && bus.BYTE_READY)
            obs_q.push_back({bus.BYTE_OUT, bus.BYTE_DC, bus.PARAM_IDX});
        if (bus.FRAME_ERR)
            ferr_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] b, input logic dc, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            MOSI = b[7-i];
            DC   = dc;
            SCL  = 1'b0;
            cyc(4);
            SCL  = 1'b1;
            cyc(4);
        end
    endtask

    task automatic model_byte(input logic [7:0] b, input logic dc, input logic loaded);
        if (!dc) begin
            m_last_cmd = b;
            m_pidx     = 8'd0;
        end else if (m_pidx != 8'd255) begin
            m_pidx = m_pidx + 8'd1;
        end
        if (loaded) begin
            exp_q.push_back({b, dc, m_pidx});
            m_count = m_count + 16'd1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dc);
        send_bits(b, dc, 8);
        model_byte(b, dc, 1'b1);
    endtask

    task automatic cs_low();
        SCL = 1'b0;
        CS  = 1'b0;
        cyc(4);
    endtask

    task automatic cs_high();
        SCL = 1'b0;
        cyc(4);
        CS = 1'b1;
        cyc(8);
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        bus.BYTE_READY = 1'b1;
        cyc(3);
        RST_N = 1'b1;
        cyc(2);
        n_cmp++;
        if ({bus.BYTE_OUT, bus.BYTE_DC, bus.PARAM_IDX, bus.LAST_CMD, bus.FRAME_ERR,
             bus.OVERRUN} !== 27'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: out %h dc %b idx %h cmd %h ferr %b ovr %b, want all 0",
                     bus.BYTE_OUT, bus.BYTE_DC, bus.PARAM_IDX, bus.LAST_CMD, bus.FRAME_ERR,
                     bus.OVERRUN);
        end
        n_cmp++;
        if (bus.BYTE_VALID !== 1'b0 || bus.BYTE_COUNT !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_valid_count: valid %b count %0d, want 0 0",
                     bus.BYTE_VALID, bus.BYTE_COUNT);
        end
    endtask

    task automatic test_basic();
        logic [16:0] o, e;
        int f0;
        f0 = ferr_cnt;
        cs_low();
        send_byte(8'hB1, 1'b0);
        send_byte(8'h05, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h3C, 1'b1);
        cs_high();
        n_cmp++;
        if (obs_q.size() != 4) begin
            n_bad++;
            $display("FAIL basic_nbytes: got %0d want 4", obs_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL basic_byte: got %h/%0d/%0d want %h/%0d/%0d",
                         o[16:9], o[8], o[7:0], e[16:9], e[8], e[7:0]);
            end
        end
        obs_q.delete();
        exp_q.delete();
        n_cmp++;
        if (bus.LAST_CMD !== 8'hB1 || bus.BYTE_COUNT !== 16'd4) begin
            n_bad++;
            $display("FAIL basic_cmd_count: cmd %h count %0d want b1 4",
                     bus.LAST_CMD, bus.BYTE_COUNT);
        end
        n_cmp++;
        if (ferr_cnt != f0 || bus.OVERRUN !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_errors: ferr pulses %0d overrun %b want 0 0",
                     ferr_cnt - f0, bus.OVERRUN);
        end
    endtask

    task automatic test_latency();
        logic [7:0] b;
        logic dc;
        logic [16:0] o, e;
        b  = 8'($urandom_range(0, 255));
        dc = 1'($urandom_range(0, 1));
        cs_low();
        send_bits(b, dc, 7);
        MOSI = b[0];
        SCL  = 1'b0;
        cyc(4);
        SCL  = 1'b1;
        @(posedge CLK);  // t0: stage 1 captures the 8th SCL high
        #1;
        cyc(1);
        n_cmp++;
        if (bus.BYTE_VALID !== 1'b0) begin
            n_bad++;
            $display("FAIL latency_early: valid %b at t0+1 want 0", bus.BYTE_VALID);
        end
        cyc(1);
        n_cmp++;
        if (bus.BYTE_VALID !== 1'b1 || bus.BYTE_OUT !== b) begin
            n_bad++;
            $display("FAIL latency_t0p2: valid %b out %h want 1 %h", bus.BYTE_VALID,
                     bus.BYTE_OUT, b);
        end
        cyc(1);
        model_byte(b, dc, 1'b1);
        cs_high();
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL latency_nbytes: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL latency_byte: got %h/%0d/%0d want %h/%0d/%0d",
                         o[16:9], o[8], o[7:0], e[16:9], e[8], e[7:0]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_abort();
        logic [16:0] o, e;
        int f0;
        f0 = ferr_cnt;
        cs_low();
        send_bits(8'($urandom_range(0, 255)), 1'b1, 5);
        cs_high();
        n_cmp++;
        if (ferr_cnt != f0 + 1 || obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL abort_pulse: ferr pulses %0d bytes %0d want 1 0",
                     ferr_cnt - f0, obs_q.size());
        end
        cs_low();
        send_byte(8'h2A, 1'b0);
        cs_high();
        n_cmp++;
        if (obs_q.size() != 1) begin
            n_bad++;
            $display("FAIL abort_nbytes: got %0d want 1", obs_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL abort_next_byte: got %h/%0d/%0d want %h/%0d/%0d",
                         o[16:9], o[8], o[7:0], e[16:9], e[8], e[7:0]);
            end
        end
        obs_q.delete();
        exp_q.delete();
        n_cmp++;
        if (ferr_cnt != f0 + 1) begin
            n_bad++;
            $display("FAIL abort_single: ferr pulses %0d want 1", ferr_cnt - f0);
        end
    endtask

    task automatic test_saturation();
        logic [16:0] o, e;
        int k;
        cs_low();
        send_byte(8'h2C, 1'b0);
        for (int i = 0; i < 300; i++)
            send_byte(8'($urandom_range(0, 255)), 1'b1);
        send_byte(8'h29, 1'b0);
        send_byte(8'($urandom_range(0, 255)), 1'b1);
        cs_high();
        n_cmp++;
        if (obs_q.size() != 303) begin
            n_bad++;
            $display("FAIL sat_nbytes: got %0d want 303", obs_q.size());
        end
        k = 0;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL sat_byte%0d: got %h/%0d/%0d want %h/%0d/%0d", k,
                         o[16:9], o[8], o[7:0], e[16:9], e[8], e[7:0]);
            end
            if (k == 300 || k == 301) begin
                n_cmp++;
                if (o[7:0] !== ((k == 300) ? 8'd255 : 8'd0)) begin
                    n_bad++;
                    $display("FAIL sat_idx%0d: got %0d", k, o[7:0]);
                end
            end
            k++;
        end
        obs_q.delete();
        exp_q.delete();
        n_cmp++;
        if (bus.LAST_CMD !== 8'h29) begin
            n_bad++;
            $display("FAIL sat_last_cmd: got %h want 29", bus.LAST_CMD);
        end
    endtask

    task automatic test_random();
        logic [16:0] o, e;
        int f0, naborts, nb;
        f0 = ferr_cnt;
        naborts = 0;
        for (int f = 0; f < 8; f++) begin
            cs_low();
            nb = int'($urandom_range(1, 5));
            for (int i = 0; i < nb; i++)
                send_byte(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                send_bits(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                          int'($urandom_range(1, 7)));
                naborts++;
            end
            cs_high();
        end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL rand_nbytes: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL rand_byte: got %h/%0d/%0d want %h/%0d/%0d",
                         o[16:9], o[8], o[7:0], e[16:9], e[8], e[7:0]);
            end
        end
        obs_q.delete();
        exp_q.delete();
        n_cmp++;
        if (bus.LAST_CMD !== m_last_cmd || bus.BYTE_COUNT !== m_count) begin
            n_bad++;
            $display("FAIL rand_cmd_count: cmd %h count %0d want %h %0d",
                     bus.LAST_CMD, bus.BYTE_COUNT, m_last_cmd, m_count);
        end
        n_cmp++;
        if (ferr_cnt - f0 != naborts) begin
            n_bad++;
            $display("FAIL rand_ferr: got %0d want %0d", ferr_cnt - f0, naborts);
        end
    endtask

    task automatic test_overrun();
        logic [16:0] o, e;
        bus.BYTE_READY = 1'b0;
        cs_low();
        send_bits(8'hAA, 1'b0, 8);
        model_byte(8'hAA, 1'b0, 1'b1);
        send_bits(8'h55, 1'b1, 8);
        model_byte(8'h55, 1'b1, 1'b0);
        cs_high();
        n_cmp++;
        if (bus.BYTE_OUT !== 8'hAA || bus.BYTE_VALID !== 1'b1 || bus.OVERRUN !== 1'b1) begin
            n_bad++;
            $display("FAIL ovr_hold: out %h valid %b ovr %b want aa 1 1", bus.BYTE_OUT,
                     bus.BYTE_VALID, bus.OVERRUN);
        end
        n_cmp++;
        if (bus.BYTE_COUNT !== m_count || bus.LAST_CMD !== 8'hAA) begin
            n_bad++;
            $display("FAIL ovr_count: count %0d cmd %h want %0d aa", bus.BYTE_COUNT,
                     bus.LAST_CMD, m_count);
        end
        bus.BYTE_READY = 1'b1;
        cyc(1);
        bus.BYTE_READY = 1'b0;
        n_cmp++;
        if (bus.BYTE_VALID !== 1'b0 || bus.OVERRUN !== 1'b1) begin
            n_bad++;
            $display("FAIL ovr_accept: valid %b ovr %b want 0 1", bus.BYTE_VALID, bus.OVERRUN);
        end
        cyc(2);
        bus.BYTE_READY = 1'b1;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL ovr_byte: got %h/%0d/%0d want %h/%0d/%0d",
                         o[16:9], o[8], o[7:0], e[16:9], e[8], e[7:0]);
            end
        end
        n_cmp++;
        if (obs_q.size() != 0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL ovr_nbytes: left obs %0d exp %0d want 0 0", obs_q.size(),
                     exp_q.size());
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid_byte();
        logic [16:0] o, e;
        int f0;
        bus.BYTE_READY = 1'b1;
        f0 = ferr_cnt;
        cs_low();
        send_bits(8'($urandom_range(0, 255)), 1'b0, 4);
        RST_N = 1'b0;
        CS    = 1'b1;
        SCL   = 1'b0;
        cyc(1);
        RST_N = 1'b1;
        n_cmp++;
        if ({bus.BYTE_OUT, bus.BYTE_DC, bus.PARAM_IDX, bus.LAST_CMD, bus.BYTE_VALID,
             bus.FRAME_ERR, bus.OVERRUN} !== 28'd0 || bus.BYTE_COUNT !== 16'd0) begin
            n_bad++;
            $display("FAIL rstmid_outputs: out %h idx %h cmd %h valid %b ovr %b count %0d",
                     bus.BYTE_OUT, bus.PARAM_IDX, bus.LAST_CMD, bus.BYTE_VALID, bus.OVERRUN,
                     bus.BYTE_COUNT);
        end
        obs_q.delete();
        exp_q.delete();
        m_last_cmd = 8'd0;
        m_pidx     = 8'd0;
        m_count    = 16'd0;
        cyc(4);
        cs_low();
        send_byte(8'h11, 1'b0);
        cs_high();
        n_cmp++;
        if (ferr_cnt != f0 || obs_q.size() != 1) begin
            n_bad++;
            $display("FAIL rstmid_ferr: ferr pulses %0d bytes %0d want 0 1", ferr_cnt - f0,
                     obs_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL rstmid_byte: got %h/%0d/%0d want %h/%0d/%0d",
                         o[16:9], o[8], o[7:0], e[16:9], e[8], e[7:0]);
            end
        end
        n_cmp++;
        if (bus.BYTE_COUNT !== 16'd1 || bus.LAST_CMD !== 8'h11 || bus.OVERRUN !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_state: count %0d cmd %h ovr %b want 1 11 0",
                     bus.BYTE_COUNT, bus.LAST_CMD, bus.OVERRUN);
        end
    endtask

    initial begin
        bus.BYTE_READY = 1'b1;
        test_reset();
        test_basic();
        test_latency();
        test_abort();
        test_saturation();
        test_random();
        test_overrun();
        test_reset_mid_byte();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_lcd_rx_decoder.md
Name: spi_lcd_rx_decoder

Overview:
- Passive receiver for the 4-wire LCD SPI bus (CS, SCL, DC, MOSI) our LCD transmitters drive.
- Oversamples the bus on the system clock, deserialises bytes MSB-first and tags each byte as command or parameter.
- Presents each byte on a valid/ready output with command/parameter bookkeeping.
- Used for on-chip loopback checking of the init and frame-rate-control sequencers, and as a bench-side bus monitor.

Parameters:
- SYNC_STAGES, 2, synchroniser depth for all four bus inputs (min 2).
- CNT_W, 16, width of the accepted-byte counter.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  synchronous active-low reset; one clock, sampled on rising CLK.
- SCL  in  1  bus clock, asynchronous to CLK.
- CS  in  1  chip select, active low, async.
- DC  in  1  0 = command, 1 = parameter/data, async.
- MOSI  in  1  serial data, MSB first, async.
- BYTE_OUT  out  8  received byte.
- BYTE_DC  out  1  DC level captured with the byte.
- PARAM_IDX  out  8  0 for a command; 1..255 for the nth parameter after the last command.
- LAST_CMD  out  8  most recent command byte seen on the bus.
- BYTE_VALID  out  1  output holds an unconsumed byte.
- BYTE_READY  in  1  consumer accepts when BYTE_VALID && BYTE_READY.
- FRAME_ERR  out  1  one-cycle pulse when CS deasserts mid-byte.
- OVERRUN  out  1  sticky: a completed byte was dropped.
- BYTE_COUNT  out  CNT_W  bytes loaded into the output register; wraps.

Behaviour:
- Reset (RST_N low at CLK edge):
  - All outputs go to 0: BYTE_OUT, BYTE_DC, PARAM_IDX, LAST_CMD, BYTE_VALID, FRAME_ERR, OVERRUN, BYTE_COUNT.
  - State goes to IDLE; shift register and bit counter clear.
  - Synchronisers reset CS stages to 1 and SCL, DC, MOSI stages to 0.
  - Internal param counter clears.
  - Reset mid-byte discards the partial byte without a FRAME_ERR.
- Inputs: each input passes through SYNC_STAGES flops. SCL rise = synced SCL 1 && previous synced SCL 0.
- Bus timing requirement: SCL high and low each ≥ SYNC_STAGES+1 CLK. Faster SCL is out of scope and gives undefined decode.
- FSM:
  - IDLE: synced CS = 1. Bit counter = 0. Go to SHIFT when synced CS = 0.
  - SHIFT:
    - On each SCL rise, shift synced MOSI in at the LSB end (first bit ends at bit 7) and increment the bit counter.
    - On the 8th rise, sample synced DC in the same cycle, complete the byte and reset the bit counter to 0. Stay in SHIFT; bytes may be back-to-back with CS held low.
    - CS goes high with the bit counter at 0: go to IDLE.
    - CS goes high with the bit counter at 1..7: go to ABORT.
  - ABORT (1 cycle): pulse FRAME_ERR, discard the partial byte, go to IDLE. The param counter is not changed.
  - CS rise and SCL rise in the same cycle: CS wins; the SCL edge is ignored.
- Byte completion, internal tracking (applies to every completed byte, accepted or dropped):
  - Command (DC = 0): LAST_CMD <= byte; param counter <= 0.
  - Parameter (DC = 1): param counter += 1, saturating at 255.
- Output register:
  - Loads when a byte completes and the register is free (!BYTE_VALID, or BYTE_READY in the same cycle).
  - Load sets BYTE_OUT, BYTE_DC, PARAM_IDX (the updated counter value), BYTE_VALID = 1, BYTE_COUNT += 1.
  - Completion with BYTE_VALID && !BYTE_READY: byte dropped, OVERRUN <= 1 (cleared only by reset), BYTE_VALID stays 1, held data unchanged.
  - Accept with no completion that cycle: BYTE_VALID <= 0.
- Latency: let t0 be the CLK edge where stage 1 first captures the 8th SCL high. BYTE_VALID is 1 after edge t0+SYNC_STAGES.
- Parameter-index example: a data byte with no preceding command gets PARAM_IDX = 1 and LAST_CMD stays 0.

Test Plan:
- SCL = 4 CLK high / 4 CLK low, CS low, bytes B1 (DC = 0), then 05, 3C, 3C (DC = 1), CS high, READY = 1 -> four outputs:
  - (B1, 0, idx 0), (05, 1, 1), (3C, 1, 2), (3C, 1, 3).
  - LAST_CMD = B1, BYTE_COUNT = 4, FRAME_ERR and OVERRUN never set.
- Latency check, SYNC_STAGES = 2 -> BYTE_VALID rises exactly 2 CLK edges after stage 1 captures the 8th SCL high.
- READY held 0, two bytes AA then 55 sent -> BYTE_OUT stays AA, OVERRUN = 1, BYTE_COUNT = 1. READY = 1 for one cycle -> BYTE_VALID = 0, OVERRUN stays 1.
- CS raised after 5 bits, then full byte 2A (DC = 0) -> one FRAME_ERR pulse, no output for the partial byte, next output is 2A with PARAM_IDX = 0.
- 300 parameter bytes after command 2C, READY = 1 -> PARAM_IDX saturates at 255. A following command resets it to 0.
- RST_N low for one cycle mid-byte, then a clean byte 11 (DC = 0) -> all outputs 0 after reset, FRAME_ERR never pulses, next output is 11.
